// File: rtl/secuenciador_lectura_pkg.sv
// Shared definitions for the read sequencer: step-code geometry, FSM
// state encoding and a helper that classifies data-read steps.
package secuenciador_lectura_pkg;

  // Width of the step code driven to the read-step decoder.
  localparam int ANCHO_PASO = 5;

  // Width of the per-step cycle timer.
  localparam int ANCHO_TMR = 8;

  // Step code shown while idle.
  localparam logic [ANCHO_PASO-1:0] PASO_REPOSO = 5'd0;

  // First step code of every sequence.
  localparam logic [ANCHO_PASO-1:0] PASO_INICIAL = 5'd1;

  // Terminal step code, shown for exactly one cycle at the end.
  localparam logic [ANCHO_PASO-1:0] PASO_FINAL = 5'd21;

  // Data-read steps are the even codes in this closed range.
  localparam logic [ANCHO_PASO-1:0] PRIMER_PASO_DATOS = 5'd2;
  localparam logic [ANCHO_PASO-1:0] ULTIMO_PASO_DATOS = 5'd20;

  // FSM state encoding; 2'b11 is unused and recovers to REPOSO.
  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    PASO   = 2'b01,
    FIN    = 2'b10
  } estado_t;

  // True for the step codes whose last cycle carries a capture strobe.
  function automatic logic es_paso_datos(input logic [ANCHO_PASO-1:0] paso);
    return (paso >= PRIMER_PASO_DATOS) && (paso <= ULTIMO_PASO_DATOS) &&
           (paso[0] == 1'b0);
  endfunction

endpackage

// File: rtl/secuenciador_lectura_temporizador_paso.sv
// Step timer: counts the cycles a step code has been held and flags the
// last cycle of the step. Clear has priority over enable; an out-of-range
// count wraps back to zero on the next enabled edge.
module temporizador_paso
  import secuenciador_lectura_pkg::*;
#(
  parameter int CICLOS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [ANCHO_TMR-1:0] TMR_ULTIMO = ANCHO_TMR'(CICLOS - 1);

  logic [ANCHO_TMR-1:0] r_tmr;

  // Cycle counter within the current step, wrapping at the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr <= 8'd0;
    end else if (i_clr) begin
      r_tmr <= 8'd0;
    end else if (i_en) begin
      if (r_tmr >= TMR_ULTIMO) begin
        r_tmr <= 8'd0;
      end else begin
        r_tmr <= r_tmr + 8'd1;
      end
    end else begin
      r_tmr <= r_tmr;
    end
  end

  assign o_tc = (r_tmr == TMR_ULTIMO);

endmodule

// File: rtl/secuenciador_lectura.sv
// Read sequencer: on a start request walks the step code 1..ULTIMO_PASO-1,
// holding each code CICLOS_PASO cycles, then shows ULTIMO_PASO for one
// cycle with a completion pulse. Capture strobes mark the last cycle of
// each even data-read step. All outputs are decoded from registered state.
module secuenciador_lectura
  import secuenciador_lectura_pkg::*;
#(
  parameter int                     CICLOS_PASO = 10,
  parameter logic [ANCHO_PASO-1:0]  ULTIMO_PASO = PASO_FINAL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio_L,
  input  logic                  abortar_L,
  output logic [ANCHO_PASO-1:0] ctrl_L,
  output logic                  ocupado_L,
  output logic                  cap_L,
  output logic                  listo_L
);

  estado_t               r_estado;
  logic [ANCHO_PASO-1:0] r_paso;

  logic w_fin_paso;
  logic w_paso_ilegal;
  logic w_clr_tmr;
  logic w_en_tmr;

  // A step code outside 1..ULTIMO_PASO-1 while stepping is corrupt state.
  assign w_paso_ilegal = (r_paso == PASO_REPOSO) || (r_paso >= ULTIMO_PASO);

  // The timer only runs while stepping; any exit from PASO restarts it at 0.
  assign w_en_tmr  = (r_estado == PASO);
  assign w_clr_tmr = (r_estado != PASO) || abortar_L || w_paso_ilegal;

  temporizador_paso #(
    .CICLOS (CICLOS_PASO)
  ) u_temporizador_paso (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr_tmr),
    .i_en  (w_en_tmr),
    .o_tc  (w_fin_paso)
  );

  // Sequencer FSM and step-code register; abort beats both start and advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= REPOSO;
      r_paso   <= PASO_REPOSO;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (inicio_L && !abortar_L) begin
            r_estado <= PASO;
            r_paso   <= PASO_INICIAL;
          end else begin
            r_estado <= REPOSO;
            r_paso   <= PASO_REPOSO;
          end
        end
        PASO: begin
          if (abortar_L || w_paso_ilegal) begin
            r_estado <= REPOSO;
            r_paso   <= PASO_REPOSO;
          end else if (w_fin_paso) begin
            if (r_paso == (ULTIMO_PASO - 5'd1)) begin
              r_estado <= FIN;
              r_paso   <= ULTIMO_PASO;
            end else begin
              r_estado <= PASO;
              r_paso   <= r_paso + 5'd1;
            end
          end else begin
            r_estado <= PASO;
            r_paso   <= r_paso;
          end
        end
        FIN: begin
          // Single terminal cycle; abort lands in the same place.
          r_estado <= REPOSO;
          r_paso   <= PASO_REPOSO;
        end
        default: begin
          r_estado <= REPOSO;
          r_paso   <= PASO_REPOSO;
        end
      endcase
    end
  end

  // Moore output decode from the state, step and timer registers.
  assign ctrl_L    = r_paso;
  assign ocupado_L = (r_estado == PASO) || (r_estado == FIN);
  assign listo_L   = (r_estado == FIN);
  assign cap_L     = (r_estado == PASO) && w_fin_paso && es_paso_datos(r_paso);

endmodule

// File: tb/tb_secuenciador_lectura.sv
// Self-checking bench for secuenciador_lectura with CICLOS_PASO=4.
module tb_secuenciador_lectura;

  localparam int C = 4;
  localparam int NPASOS = 20;

  logic       clk;
  logic       reset;
  logic       inicio_L;
  logic       abortar_L;
  logic [4:0] ctrl_L;
  logic       ocupado_L;
  logic       cap_L;
  logic       listo_L;

  int n_vec = 0;
  int n_err = 0;
  int cnt_cap = 0;
  int cnt_listo = 0;
  int cnt_ocup = 0;

  // Reference model: a sequence is "active" with t cycles elapsed since start.
  bit m_activo;
  int m_t;

  secuenciador_lectura #(
    .CICLOS_PASO (C),
    .ULTIMO_PASO (5'd21)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio_L  (inicio_L),
    .abortar_L (abortar_L),
    .ctrl_L    (ctrl_L),
    .ocupado_L (ocupado_L),
    .cap_L     (cap_L),
    .listo_L   (listo_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update: start, run NPASOS*C stepping cycles plus one terminal cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_activo <= 1'b0;
      m_t      <= 0;
    end else if (m_activo) begin
      if (abortar_L || m_t == NPASOS * C) begin
        m_activo <= 1'b0;
        m_t      <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (inicio_L && !abortar_L) begin
      m_activo <= 1'b1;
      m_t      <= 0;
    end
  end

  // One cycle: wait for the falling edge, accumulate counts, compare to model.
  task automatic tick();
    int  e_ctrl;
    bit  e_cap, e_listo, e_ocup;
    @(negedge clk);
    if (cap_L)     cnt_cap++;
    if (listo_L)   cnt_listo++;
    if (ocupado_L) cnt_ocup++;
    e_ctrl = 0; e_cap = 1'b0; e_listo = 1'b0; e_ocup = 1'b0;
    if (m_activo) begin
      e_ocup = 1'b1;
      if (m_t < NPASOS * C) begin
        e_ctrl = m_t / C + 1;
        e_cap  = (e_ctrl % 2 == 0) && (m_t % C == C - 1);
      end else begin
        e_ctrl  = 21;
        e_listo = 1'b1;
      end
    end
    n_vec++;
    if (ctrl_L !== 5'(e_ctrl) || cap_L !== e_cap || listo_L !== e_listo ||
        ocupado_L !== e_ocup) begin
      n_err++;
      $display("FAIL model t=%0t: got ctrl=%0d cap=%b listo=%b ocup=%b, expected ctrl=%0d cap=%b listo=%b ocup=%b",
               $time, ctrl_L, cap_L, listo_L, ocupado_L, e_ctrl, e_cap, e_listo, e_ocup);
    end
  endtask

  // Hand-computed literal expectation.
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bounded wait for a given step code.
  task automatic wait_ctrl(input int v, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (ctrl_L == 5'(v)) ok = 1'b1;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic clr_cnt();
    cnt_cap = 0; cnt_listo = 0; cnt_ocup = 0;
  endtask

  initial begin
    bit visto;
    reset = 1'b1; inicio_L = 1'b0; abortar_L = 1'b0;
    tick(); tick();
    chk("reset_ctrl", int'(ctrl_L), 0);
    chk("reset_ocupado", int'(ocupado_L), 0);
    chk("reset_cap", int'(cap_L), 0);
    chk("reset_listo", int'(listo_L), 0);
    reset = 1'b0;
    tick(); tick();

    // Full sequence from a one-cycle start pulse.
    clr_cnt();
    inicio_L = 1'b1;
    tick();
    chk("seq1_first_ctrl", int'(ctrl_L), 1);
    inicio_L = 1'b0;
    repeat (89) tick();
    chk("seq1_ocupado_cycles", cnt_ocup, 81);
    chk("seq1_cap_pulses", cnt_cap, 10);
    chk("seq1_listo_pulses", cnt_listo, 1);
    chk("seq1_end_ctrl", int'(ctrl_L), 0);

    // Start held high for 40 cycles mid-sequence must not restart it.
    clr_cnt();
    inicio_L = 1'b1;
    tick();
    chk("seq2_first_ctrl", int'(ctrl_L), 1);
    repeat (40) tick();
    inicio_L = 1'b0;
    visto = 1'b0;
    for (int i = 0; i < 60 && !visto; i++) begin
      tick();
      if (listo_L) visto = 1'b1;
    end
    chk("seq2_listo_seen", int'(visto), 1);
    chk("seq2_ocupado_cycles", cnt_ocup, 81);
    chk("seq2_cap_pulses", cnt_cap, 10);
    tick();
    chk("seq2_idle_after_fin", int'(ctrl_L), 0);
    inicio_L = 1'b1;
    tick();
    chk("restart_ctrl", int'(ctrl_L), 1);
    inicio_L = 1'b0;

    // Abort at step 7, last timer cycle.
    clr_cnt();
    wait_ctrl(7, 40, "wait_step7");
    repeat (3) tick();
    chk("pre_abort_ctrl", int'(ctrl_L), 7);
    abortar_L = 1'b1;
    tick();
    abortar_L = 1'b0;
    chk("abort_ctrl", int'(ctrl_L), 0);
    chk("abort_ocupado", int'(ocupado_L), 0);
    repeat (3) tick();
    chk("abort_no_listo", cnt_listo, 0);

    // Abort coinciding with the step advance at step 19.
    inicio_L = 1'b1;
    tick();
    inicio_L = 1'b0;
    clr_cnt();
    wait_ctrl(19, 100, "wait_step19");
    repeat (3) tick();
    abortar_L = 1'b1;
    tick();
    abortar_L = 1'b0;
    chk("abort_adv_ctrl", int'(ctrl_L), 0);
    repeat (3) tick();
    chk("abort_adv_no_listo", cnt_listo, 0);

    // Abort and start together while idle: stay idle.
    abortar_L = 1'b1; inicio_L = 1'b1;
    tick();
    abortar_L = 1'b0; inicio_L = 1'b0;
    chk("abort_beats_start", int'(ocupado_L), 0);
    tick();

    // Asynchronous reset at step 12, checked before the next rising edge.
    inicio_L = 1'b1;
    tick();
    inicio_L = 1'b0;
    clr_cnt();
    wait_ctrl(12, 60, "wait_step12");
    #2 reset = 1'b1;
    #1;
    chk("async_ctrl", int'(ctrl_L), 0);
    chk("async_ocupado", int'(ocupado_L), 0);
    chk("async_cap", int'(cap_L), 0);
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("post_reset_idle", int'(ocupado_L), 0);
    chk("post_reset_no_listo", cnt_listo, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
